// File: rtl/ram_burst_pkg.sv
`default_nettype none
// =============================================================================
// Package  : ram_burst_pkg
// Brief    : Shared types and constants for the RAM burst master.
// Revision : 1.0 - initial release
// =============================================================================
package ram_burst_pkg;

    localparam int RAM_ADDR_SIZE   = 11;
    localparam int RAM_WORD_SIZE   = 32;
    localparam int RAM_MEMORY_SIZE = 2048;
    localparam int RD_BUF_DEPTH    = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_DRAIN = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef struct packed {
        logic                     wr;
        logic [RAM_ADDR_SIZE-1:0] addr;
        logic [RAM_ADDR_SIZE:0]   len;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/ram_burst_master_if.sv
`default_nettype none
// =============================================================================
// Interface: ram_burst_master_if
// Brief    : Command, RAM and stream signals of the burst master.
// Config   : RAM_BURST_COUNT_EN adds xfer_count
// Revision : 1.0 - initial release
// =============================================================================
interface ram_burst_master_if #(
    parameter int ADDR_SIZE = 11,
    parameter int WORD_SIZE = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_wr;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [ADDR_SIZE:0]   cmd_len;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic                 ram_wr;
    logic [WORD_SIZE-1:0] ram_din;
    logic [WORD_SIZE-1:0] ram_dout;
    logic                 s_valid;
    logic                 s_ready;
    logic [WORD_SIZE-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [WORD_SIZE-1:0] m_data;
    logic                 busy;
    logic                 done;
`ifdef RAM_BURST_COUNT_EN
    logic [ADDR_SIZE:0]   xfer_count;
`endif

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, ram_dout, s_valid, s_data, m_ready,
        output cmd_ready, ram_addr, ram_wr, ram_din, s_ready, m_valid, m_data, busy, done
`ifdef RAM_BURST_COUNT_EN
        , output xfer_count
`endif
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, ram_dout, s_valid, s_data, m_ready,
        input  cmd_ready, ram_addr, ram_wr, ram_din, s_ready, m_valid, m_data, busy, done
`ifdef RAM_BURST_COUNT_EN
        , input xfer_count
`endif
    );

endinterface
`default_nettype wire

// File: rtl/ram_burst_rdbuf.sv
`default_nettype none
// =============================================================================
// Module   : ram_burst_rdbuf
// Brief    : Small synchronous FIFO used as the read-data skid buffer.
// Revision : 1.0 - initial release
// =============================================================================
module ram_burst_rdbuf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full buffer may still accept a word in the same cycle its head leaves.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// =============================================================================
// Module   : ram_burst_master
// Brief    : Burst initiator for a 1-cycle-latency single-port RAM with
//            valid/ready read and write streams.
// Config   : RAM_BURST_COUNT_EN adds the xfer_count output
// Revision : 1.0 - initial release
// =============================================================================
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int ADDR_SIZE   = RAM_ADDR_SIZE,
    parameter int WORD_SIZE   = RAM_WORD_SIZE,
    parameter int MEMORY_SIZE = RAM_MEMORY_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    ram_burst_master_if.master bus
);
    localparam int                   c_CNT_W   = $clog2(RD_BUF_DEPTH + 1);
    localparam logic [ADDR_SIZE:0]   c_MAX_LEN = (ADDR_SIZE + 1)'(MEMORY_SIZE);
    localparam logic [ADDR_SIZE:0]   c_ONE     = (ADDR_SIZE + 1)'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    cmd_t                 w_cmd;
    logic [ADDR_SIZE-1:0] r_cur;
    logic [ADDR_SIZE:0]   r_rem;
    logic                 r_in_flight;
    logic                 w_accept;
    logic                 w_rd_issue;
    logic                 w_wr_fire;
    logic                 w_pop;
    logic                 w_buf_full;
    logic                 w_buf_empty;
    logic [c_CNT_W-1:0]   w_buf_count;
    logic [c_CNT_W:0]     w_occ;
    logic [WORD_SIZE-1:0] w_buf_dout;

    always_comb begin
        w_cmd.wr   = bus.cmd_wr;
        w_cmd.addr = bus.cmd_addr;
        w_cmd.len  = (bus.cmd_len > c_MAX_LEN) ? c_MAX_LEN : bus.cmd_len;
    end

    assign w_accept = (r_state == IDLE) & bus.cmd_valid;
    assign w_pop    = ~w_buf_empty & bus.m_ready;
    // Occupancy after this cycle's pop; counting the pop keeps one word per cycle.
    assign w_occ    = (c_CNT_W + 1)'(w_buf_count) + (c_CNT_W + 1)'(r_in_flight)
                    - (c_CNT_W + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (w_cmd.len == '0) w_state_nxt = DONE;
                    else if (w_cmd.wr)   w_state_nxt = WR;
                    else                 w_state_nxt = RD;
                end
            end
            RD:       if (w_rd_issue && r_rem == c_ONE)    w_state_nxt = RD_DRAIN;
            RD_DRAIN: if (w_buf_empty && !r_in_flight)     w_state_nxt = DONE;
            WR:       if (w_wr_fire && r_rem == c_ONE)     w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.ram_wr    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_din   = '0;
        bus.s_ready   = 1'b0;
        w_rd_issue    = 1'b0;
        w_wr_fire     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            RD: begin
                bus.ram_addr = r_cur;
                w_rd_issue   = (w_occ < (c_CNT_W + 1)'(RD_BUF_DEPTH)) & ~(w_buf_full & ~w_pop);
            end
            WR: begin
                bus.ram_addr = r_cur;
                bus.s_ready  = 1'b1;
                if (bus.s_valid) begin
                    w_wr_fire   = 1'b1;
                    bus.ram_wr  = 1'b1;
                    bus.ram_din = bus.s_data;
                end
            end
            DONE:     bus.done = 1'b1;
            default:  bus.busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur       <= '0;
            r_rem       <= '0;
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_rd_issue;
            if (w_accept) begin
                r_cur <= w_cmd.addr;
                r_rem <= w_cmd.len;
            end else if (w_rd_issue || w_wr_fire) begin
                r_cur <= r_cur + ADDR_SIZE'(1);
                r_rem <= r_rem - c_ONE;
            end
        end
    end

    // RAM output is registered, so the word issued last cycle lands here now.
    ram_burst_rdbuf #(
        .WIDTH (WORD_SIZE),
        .DEPTH (RD_BUF_DEPTH)
    ) u_rdbuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_in_flight),
        .i_din   (bus.ram_dout),
        .i_pop   (w_pop),
        .o_dout  (w_buf_dout),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    assign bus.m_valid = ~w_buf_empty;
    assign bus.m_data  = w_buf_empty ? '0 : w_buf_dout;

`ifdef RAM_BURST_COUNT_EN
    logic [ADDR_SIZE:0] r_xfer_count;

    always_ff @(posedge clk) begin
        if (rst || w_accept)         r_xfer_count <= '0;
        else if (w_pop || w_wr_fire) r_xfer_count <= r_xfer_count + c_ONE;
    end

    assign bus.xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire
